// File: rtl/perm_mem_pkg.sv
// Shared types and defaults for the permutation-state lane store.
// Coordinate width helper keeps the ports legal even for a degenerate DIM of 1.
package perm_mem_pkg;

  typedef enum logic {WM_LOAD = 1'b0, WM_XOR = 1'b1} wr_mode_e;

  typedef enum logic {CS_IDLE = 1'b0, CS_CLEAR = 1'b1} clr_state_e;

  localparam int unsigned DIM_DEF    = 5;
  localparam int unsigned LANE_W_DEF = 64;
  localparam int unsigned NRD_DEF    = 2;

  function automatic int unsigned coord_w(input int unsigned dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  localparam int unsigned CW_DEF = coord_w(DIM_DEF);

  typedef logic [CW_DEF-1:0] coord_t;

endpackage

// File: rtl/perm_state_mem_if.sv
// Request/response bundle between the absorb/squeeze front end and the lane store.
// master drives requests, slave is the lane store.
interface perm_state_mem_if
  import perm_mem_pkg::*;
#(
  parameter int unsigned LANE_W = LANE_W_DEF,
  parameter int unsigned DIM    = DIM_DEF,
  parameter int unsigned NRD    = NRD_DEF
) ();

  localparam int unsigned CW = coord_w(DIM);

  logic [NRD-1:0]             rd_en;
  logic [NRD-1:0][CW-1:0]     rd_x;
  logic [NRD-1:0][CW-1:0]     rd_y;
  logic [NRD-1:0][LANE_W-1:0] rd_data;
  logic [NRD-1:0]             rd_vld;

  logic                       wr_en;
  logic [CW-1:0]              wr_x;
  logic [CW-1:0]              wr_y;
  wr_mode_e                   wr_mode;
  logic [LANE_W-1:0]          wr_data;

  logic                       clr_req;
  logic                       busy;
  logic                       err;

  modport master (
    output rd_en, rd_x, rd_y, wr_en, wr_x, wr_y, wr_mode, wr_data, clr_req,
    input  rd_data, rd_vld, busy, err
  );

  modport slave (
    input  rd_en, rd_x, rd_y, wr_en, wr_x, wr_y, wr_mode, wr_data, clr_req,
    output rd_data, rd_vld, busy, err
  );

endinterface

// File: rtl/perm_mem_clr_seq.sv
// Row-per-cycle clear sequencer: sweeps rows 0..DIM-1 after reset or on request.
// Requests arriving mid-sweep are ignored; reset restarts the sweep at row 0.
module perm_mem_clr_seq
  import perm_mem_pkg::*;
#(
  parameter int unsigned DIM = DIM_DEF,
  localparam int unsigned CW = coord_w(DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic [CW-1:0] clr_row,
  output logic          clr_we
);

  localparam logic [CW-1:0] LAST_ROW = CW'(DIM - 1);

  clr_state_e    state_q, state_d;
  logic [CW-1:0] row_q, row_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CS_CLEAR;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    busy    = 1'b0;
    clr_we  = 1'b0;
    unique case (state_q)
      CS_IDLE: begin
        if (clr_req) begin
          state_d = CS_CLEAR;
          row_d   = '0;
        end
      end
      CS_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = CS_IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + CW'(1);
        end
      end
    endcase
  end

  assign clr_row = row_q;

endmodule

// File: rtl/perm_state_mem.sv
// DIMxDIM lane store with NRD registered read ports, one LOAD/XOR write port
// and a sweeping clear. Reads see same-cycle writes to the same lane (write-first).
module perm_state_mem
  import perm_mem_pkg::*;
#(
  parameter int unsigned LANE_W = LANE_W_DEF,
  parameter int unsigned DIM    = DIM_DEF,
  parameter int unsigned NRD    = NRD_DEF
) (
  input logic             clk,
  input logic             rst,
  perm_state_mem_if.slave bus
);

  localparam int unsigned CW    = coord_w(DIM);
  // One extra bit so DIM itself is representable when DIM is a power of two.
  localparam logic [CW:0] DIM_C = (CW + 1)'(DIM);

  logic [LANE_W-1:0] mem_q [DIM][DIM];  // indexed [y][x]

  logic          busy;
  logic          clr_we;
  logic [CW-1:0] clr_row;

  perm_mem_clr_seq #(
    .DIM(DIM)
  ) u_clr_seq (
    .clk    (clk),
    .rst    (rst),
    .clr_req(bus.clr_req),
    .busy   (busy),
    .clr_row(clr_row),
    .clr_we (clr_we)
  );

  logic              wr_in_range;
  logic              wr_acc;
  logic [CW-1:0]     wr_xi, wr_yi;
  logic [LANE_W-1:0] wr_old, wr_new;

  logic [NRD-1:0]             rd_acc;
  logic [NRD-1:0][LANE_W-1:0] rd_lane;
  logic                       err_d;

  logic [NRD-1:0][LANE_W-1:0] rd_data_q;
  logic [NRD-1:0]             rd_vld_q;
  logic                       err_q;

  always_comb begin
    wr_in_range = ({1'b0, bus.wr_x} < DIM_C) && ({1'b0, bus.wr_y} < DIM_C);
    wr_acc      = bus.wr_en && !busy && wr_in_range;
    // Clamp so the storage is never indexed out of bounds by a dropped request.
    wr_xi       = wr_in_range ? bus.wr_x : '0;
    wr_yi       = wr_in_range ? bus.wr_y : '0;
    wr_old      = mem_q[wr_yi][wr_xi];
    wr_new      = (bus.wr_mode == WM_XOR) ? (wr_old ^ bus.wr_data) : bus.wr_data;
    err_d       = bus.wr_en && !wr_acc;
    rd_acc      = '0;
    rd_lane     = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      logic          in_range;
      logic [CW-1:0] xi, yi;
      in_range  = ({1'b0, bus.rd_x[i]} < DIM_C) && ({1'b0, bus.rd_y[i]} < DIM_C);
      rd_acc[i] = bus.rd_en[i] && !busy && in_range;
      xi        = in_range ? bus.rd_x[i] : '0;
      yi        = in_range ? bus.rd_y[i] : '0;
      if (wr_acc && (xi == bus.wr_x) && (yi == bus.wr_y)) begin
        rd_lane[i] = wr_new;
      end else begin
        rd_lane[i] = mem_q[yi][xi];
      end
      err_d = err_d || (bus.rd_en[i] && !rd_acc[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_vld_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NRD; i++) begin
        if (rd_acc[i]) begin
          rd_data_q[i] <= rd_lane[i];
        end
      end
      rd_vld_q <= rd_acc;
      err_q    <= err_d;
    end
  end

  // Storage has no reset of its own; the clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      for (int unsigned x = 0; x < DIM; x++) begin
        mem_q[clr_row][x] <= '0;
      end
    end else if (wr_acc) begin
      mem_q[wr_yi][wr_xi] <= wr_new;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rd_vld  = rd_vld_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_perm_state_mem.sv
// Directed and random checks of perm_state_mem against a lane-array reference model.
module tb_perm_state_mem;
  import perm_mem_pkg::*;

  localparam int unsigned LW = 64;
  localparam int unsigned D  = 5;
  localparam int unsigned NR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  perm_state_mem_if #(.LANE_W(LW), .DIM(D), .NRD(NR)) bus ();

  perm_state_mem #(.LANE_W(LW), .DIM(D), .NRD(NR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [LW-1:0] model  [D][D];
  logic [LW-1:0] exp_rd [NR];
  int            left;  // clear cycles still to run

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.rd_en   = '0;
    bus.rd_x    = '0;
    bus.rd_y    = '0;
    bus.wr_en   = 1'b0;
    bus.wr_x    = '0;
    bus.wr_y    = '0;
    bus.wr_mode = WM_LOAD;
    bus.wr_data = '0;
    bus.clr_req = 1'b0;
  endtask

  task automatic rd(input int p, input int x, input int y);
    bus.rd_en[p] = 1'b1;
    bus.rd_x[p]  = coord_t'(x);
    bus.rd_y[p]  = coord_t'(y);
  endtask

  task automatic wr(input int x, input int y, input wr_mode_e m, input logic [LW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_x    = coord_t'(x);
    bus.wr_y    = coord_t'(y);
    bus.wr_mode = m;
    bus.wr_data = d;
  endtask

  task automatic zero_model();
    for (int y = 0; y < D; y++) for (int x = 0; x < D; x++) model[y][x] = '0;
  endtask

  // One clock: predict from the model, advance, compare every output, then update the model.
  task automatic cycle(input string tag);
    bit            busy_m, wacc, exp_err, clr_go;
    bit [NR-1:0]   racc;
    logic [LW-1:0] wnew;
    int            wx, wy;
    busy_m  = (left > 0);
    wx      = int'(bus.wr_x);
    wy      = int'(bus.wr_y);
    wacc    = bus.wr_en && !busy_m && wx < D && wy < D;
    wnew    = '0;
    if (wacc) wnew = (bus.wr_mode == WM_XOR) ? (model[wy][wx] ^ bus.wr_data) : bus.wr_data;
    exp_err = bus.wr_en && !wacc;
    for (int p = 0; p < NR; p++) begin
      int x;
      int y;
      x       = int'(bus.rd_x[p]);
      y       = int'(bus.rd_y[p]);
      racc[p] = bus.rd_en[p] && !busy_m && x < D && y < D;
      exp_err = exp_err || (bus.rd_en[p] && !racc[p]);
      if (racc[p]) exp_rd[p] = (wacc && x == wx && y == wy) ? wnew : model[y][x];
    end
    clr_go = bus.clr_req && !busy_m;
    @(posedge clk);
    #1;
    if (wacc) model[wy][wx] = wnew;
    if (clr_go) begin
      left = D;
      zero_model();
    end else if (busy_m) begin
      left--;
    end
    chk($sformatf("%s/rd_vld", tag), LW'(bus.rd_vld), LW'(racc));
    for (int p = 0; p < NR; p++) chk($sformatf("%s/rd_data%0d", tag, p), bus.rd_data[p], exp_rd[p]);
    chk($sformatf("%s/err", tag), LW'(bus.err), LW'(exp_err));
    chk($sformatf("%s/busy", tag), LW'(bus.busy), (left > 0) ? LW'(1) : LW'(0));
    idle();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle();
    repeat (n) @(posedge clk);
    #1;
    rst  = 1'b0;
    left = D;
    zero_model();
    for (int p = 0; p < NR; p++) exp_rd[p] = '0;
    chk("reset/busy", LW'(bus.busy), LW'(1));
    chk("reset/rd_vld", LW'(bus.rd_vld), '0);
    chk("reset/err", LW'(bus.err), '0);
    for (int p = 0; p < NR; p++) chk($sformatf("reset/rd_data%0d", p), bus.rd_data[p], '0);
  endtask

  // Counts cycles with busy high, bounded so a stuck busy cannot hang the run.
  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.busy === 1'b1) cnt++;
      cycle(tag);
    end
    chk($sformatf("%s/busy_cycles", tag), LW'(cnt), LW'(D));
  endtask

  task automatic read_all(input string tag, input bit expect_zero);
    for (int k = 0; k < D * D; k += NR) begin
      for (int p = 0; p < NR; p++) if (k + p < D * D) rd(p, (k + p) % D, (k + p) / D);
      cycle(tag);
      if (expect_zero) chk($sformatf("%s/zero%0d", tag, k), bus.rd_data[0], '0);
    end
  endtask

  initial begin
    idle();
    // 1: reset sweep
    do_reset(2);
    count_busy("t1_sweep");
    rd(0, 2, 3);
    cycle("t1_rd");
    chk("t1_lane", bus.rd_data[0], '0);
    chk("t1_vld", LW'(bus.rd_vld[0]), LW'(1));

    // 2: load then read on port 1
    wr(1, 4, WM_LOAD, 64'h0123456789ABCDEF);
    cycle("t2_wr");
    rd(1, 1, 4);
    cycle("t2_rd");
    chk("t2_lane", bus.rd_data[1], 64'h0123456789ABCDEF);

    // 3: XOR accumulate
    wr(0, 0, WM_LOAD, 64'hFF00);
    cycle("t3_load");
    wr(0, 0, WM_XOR, 64'h0FF0);
    cycle("t3_xor1");
    wr(0, 0, WM_XOR, 64'h000F);
    cycle("t3_xor2");
    rd(0, 0, 0);
    cycle("t3_rd");
    chk("t3_lane", bus.rd_data[0], 64'hF0FF);

    // 4: read/write collision
    wr(3, 2, WM_LOAD, 64'h5555);
    cycle("t4_pre");
    wr(3, 3, WM_LOAD, 64'h1);
    cycle("t4_load");
    wr(3, 3, WM_XOR, 64'hAA);
    rd(0, 3, 3);
    rd(1, 3, 2);
    cycle("t4_coll");
    chk("t4_lane0", bus.rd_data[0], 64'hAB);
    chk("t4_lane1", bus.rd_data[1], 64'h5555);

    // 5: out-of-range requests
    wr(5, 0, WM_LOAD, 64'hDEAD);
    cycle("t5_wr");
    chk("t5_err", LW'(bus.err), LW'(1));
    cycle("t5_gap");
    chk("t5_err_end", LW'(bus.err), '0);
    read_all("t5_scan", 1'b0);
    rd(0, 1, 7);
    cycle("t5_rd");
    chk("t5_rd_vld", LW'(bus.rd_vld[0]), '0);
    chk("t5_rd_err", LW'(bus.err), LW'(1));

    // 6: fill, clear, read during busy
    for (int y = 0; y < D; y++) for (int x = 0; x < D; x++) begin
      wr(x, y, WM_LOAD, {$urandom, $urandom});
      cycle("t6_fill");
    end
    bus.clr_req = 1'b1;
    cycle("t6_clr");
    rd(0, 1, 1);
    bus.clr_req = 1'b1;
    cycle("t6_busy_rd");
    chk("t6_busy_vld", LW'(bus.rd_vld[0]), '0);
    chk("t6_busy_err", LW'(bus.err), LW'(1));
    for (int k = 0; k < 10 && left > 0; k++) cycle("t6_drain");
    read_all("t6_scan", 1'b1);

    // 6b: reset at sweep row 2 restarts the sweep
    for (int x = 0; x < D; x++) begin
      wr(x, 4, WM_LOAD, {$urandom, $urandom});
      cycle("t6b_fill");
    end
    bus.clr_req = 1'b1;
    cycle("t6b_clr");
    cycle("t6b_row0");
    cycle("t6b_row1");
    do_reset(1);
    count_busy("t6b_sweep");
    read_all("t6b_scan", 1'b1);

    // 7: random traffic with frequent collisions and occasional clears
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NR; p++)
        if ($urandom_range(0, 1) == 1) rd(p, $urandom_range(0, 6), $urandom_range(0, 6));
      if ($urandom_range(0, 1) == 1)
        wr($urandom_range(0, 5), $urandom_range(0, 5),
           ($urandom_range(0, 1) == 1) ? WM_XOR : WM_LOAD, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        bus.rd_en[0] = 1'b1;
        bus.rd_x[0]  = bus.wr_x;
        bus.rd_y[0]  = bus.wr_y;
      end
      if ($urandom_range(0, 49) == 0) bus.clr_req = 1'b1;
      cycle("t7_rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
